// File: rtl/pwm_dt_pkg.sv
// Shared types for the PWM dead-time inserter: FSM states, the per-state
// output decode and the default dead-time counter width.
package pwm_dt_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        DT_TO_HI,
        HI_ON,
        DT_TO_LO,
        LO_ON,
        FAULT
    } state_t;

    typedef struct packed {
        logic hi;
        logic lo;
        logic dt;
        logic flt;
    } drive_t;

    // At most one of hi/lo is ever set, so the decoded drive cannot shoot through.
    function automatic drive_t decode_state(input state_t s);
        drive_t d;
        d = '0;
        case (s)
            HI_ON:    d.hi  = 1'b1;
            LO_ON:    d.lo  = 1'b1;
            DT_TO_HI: d.dt  = 1'b1;
            DT_TO_LO: d.dt  = 1'b1;
            FAULT:    d.flt = 1'b1;
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Dead-time down-counter: loads the gap length, counts down once per cycle
// and flags the last cycle of the gap (count == 1).
module pwm_dt_counter #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DT_WIDTH-1:0] load_val,
    input  logic                dec,
    output logic                done
);

    logic [DT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == {{(DT_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pwm_deadtime_inserter.sv
// Turns a single-ended PWM into a complementary half-bridge drive with a
// programmable both-off gap at each edge, latched fault shutdown and enable.
//
// state    | meaning
// IDLE     | disabled, both outputs off
// DT_TO_HI | gap before high side conducts
// HI_ON    | high side conducting
// DT_TO_LO | gap before low side conducts
// LO_ON    | low side conducting
// FAULT    | latched shutdown, waits for fault_clr with fault cleared
module pwm_deadtime_inserter
    import pwm_dt_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic                out_hi,
    output logic                out_lo,
    output logic                in_deadtime,
    output logic                fault_flag
);

    state_t state;
    state_t state_nx;
    drive_t drive_nx;
    logic   pwm_q;
    logic   fault_q;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_done;
    logic   zero_dt;

    assign zero_dt = (dead_time == '0);

    pwm_dt_counter #(
        .DT_WIDTH(DT_WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (dead_time),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (fault_q) begin
            state_nx = FAULT;
        end else if (state == FAULT) begin
            if (fault_clr) state_nx = IDLE;
        end else if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pwm_q) state_nx = zero_dt ? HI_ON : DT_TO_HI;
                    else       state_nx = zero_dt ? LO_ON : DT_TO_LO;
                    cnt_load = !zero_dt;
                end
                LO_ON: begin
                    if (pwm_q) begin
                        state_nx = zero_dt ? HI_ON : DT_TO_HI;
                        cnt_load = !zero_dt;
                    end
                end
                HI_ON: begin
                    if (!pwm_q) begin
                        state_nx = zero_dt ? LO_ON : DT_TO_LO;
                        cnt_load = !zero_dt;
                    end
                end
                // A pulse shorter than the gap is swallowed: fall back to the
                // side that was conducting, the new side never turns on.
                DT_TO_HI: begin
                    if (!pwm_q)        state_nx = LO_ON;
                    else if (cnt_done) state_nx = HI_ON;
                    else               cnt_dec  = 1'b1;
                end
                DT_TO_LO: begin
                    if (pwm_q)         state_nx = HI_ON;
                    else if (cnt_done) state_nx = LO_ON;
                    else               cnt_dec  = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign drive_nx = decode_state(state_nx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pwm_q       <= 1'b0;
            fault_q     <= 1'b0;
            out_hi      <= 1'b0;
            out_lo      <= 1'b0;
            in_deadtime <= 1'b0;
            fault_flag  <= 1'b0;
        end else begin
            state       <= state_nx;
            pwm_q       <= pwm_in;
            fault_q     <= fault_in;
            out_hi      <= drive_nx.hi;
            out_lo      <= drive_nx.lo;
            in_deadtime <= drive_nx.dt;
            fault_flag  <= drive_nx.flt;
        end
    end

endmodule
